// File: rtl/jam_pkg.sv
// Shared types and constants for the assignment-search datapath (cost ROM arbiter and friends).
package jam_pkg;

    localparam int IDX_W      = 3;
    localparam int COST_W     = 7;
    localparam int MINCOST_W  = 10;
    localparam int LOCK_BURST = 8;

    typedef enum logic [1:0] {IDLE, ARB, LOCK} arb_state_e;

endpackage

// File: rtl/jam_rr_pick.sv
// Combinational round-robin picker: first set bit of (req & mask) at or after ptr, wrapping.
module jam_rr_pick #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [N-1:0]  mask_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    logic [N-1:0] cand;
    int unsigned  pos;

    always_comb begin
        cand  = req_i & mask_i;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        pos   = 0;
        for (int k = 0; k < N; k++) begin
            pos = int'(ptr_i) + k;
            if (pos >= N) pos = pos - N;
            if (!any_o && cand[pos]) begin
                any_o      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/jam_cost_rom_arbiter.sv
// Round-robin sharing of the cost-ROM port among NUM_REQ search engines, with burst locking.
// Optional JAM_ARB_LOCK_LIMIT_EN: force-release a lock after LOCK_BURST consecutive owner accepts.
module jam_cost_rom_arbiter
    import jam_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ROM_LAT = 1
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ-1:0]       lock,
    input  logic [NUM_REQ*IDX_W-1:0] req_w,
    input  logic [NUM_REQ*IDX_W-1:0] req_j,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       rsp_valid,
    output logic [COST_W-1:0]        rsp_cost,
    output logic [IDX_W-1:0]         rom_W,
    output logic [IDX_W-1:0]         rom_J,
    input  logic [COST_W-1:0]        rom_Cost,
    output logic                     busy
);

    localparam int PW = $clog2(NUM_REQ);

    arb_state_e               state_q, state_d;
    logic [PW-1:0]            ptr_q, ptr_d, owner_q, owner_d, win_idx;
    logic [NUM_REQ-1:0]       mask;
    logic                     accept, hold, limit_hit;
    logic [IDX_W-1:0]         rom_w_q, rom_j_q;
    logic [ROM_LAT:0]         vld_pipe_q;
    logic [ROM_LAT:0][PW-1:0] tag_pipe_q;

    // While the owner keeps req&lock it is the only candidate; otherwise ptr_q already
    // sits at owner+1, so a release automatically gives the old owner lowest priority.
    assign hold = (state_q == LOCK) && req[owner_q] && lock[owner_q];
    assign mask = hold ? (NUM_REQ'(1) << owner_q) : '1;

    jam_rr_pick #(.N(NUM_REQ), .PW(PW)) u_pick (
        .req_i  (req),
        .mask_i (mask),
        .ptr_i  (ptr_q),
        .gnt_o  (gnt),
        .idx_o  (win_idx),
        .any_o  (accept)
    );

`ifdef JAM_ARB_LOCK_LIMIT_EN
    logic [2:0] burst_q, burst_d;
    assign limit_hit = hold && (burst_q == 3'(LOCK_BURST - 1));
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
`ifdef JAM_ARB_LOCK_LIMIT_EN
        burst_d = burst_q;
`endif
        if (!accept) begin
            state_d = IDLE;
`ifdef JAM_ARB_LOCK_LIMIT_EN
            burst_d = '0;
`endif
        end else begin
            ptr_d = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
            if (hold) begin
                state_d = limit_hit ? ARB : LOCK;
`ifdef JAM_ARB_LOCK_LIMIT_EN
                burst_d = limit_hit ? 3'd0 : burst_q + 3'd1;
`endif
            end else if (lock[win_idx]) begin
                state_d = LOCK;
                owner_d = win_idx;
`ifdef JAM_ARB_LOCK_LIMIT_EN
                burst_d = 3'd1;
`endif
            end else begin
                state_d = ARB;
`ifdef JAM_ARB_LOCK_LIMIT_EN
                burst_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            rom_w_q    <= '0;
            rom_j_q    <= '0;
            vld_pipe_q <= '0;
            tag_pipe_q <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            owner_q       <= owner_d;
            vld_pipe_q[0] <= accept;
            tag_pipe_q[0] <= win_idx;
            if (accept) begin
                rom_w_q <= req_w[win_idx*IDX_W +: IDX_W];
                rom_j_q <= req_j[win_idx*IDX_W +: IDX_W];
            end
            for (int k = 1; k <= ROM_LAT; k++) begin
                vld_pipe_q[k] <= vld_pipe_q[k-1];
                tag_pipe_q[k] <= tag_pipe_q[k-1];
            end
        end
    end

`ifdef JAM_ARB_LOCK_LIMIT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) burst_q <= '0;
        else     burst_q <= burst_d;
    end
`endif

    assign rom_W     = rom_w_q;
    assign rom_J     = rom_j_q;
    assign rsp_valid = vld_pipe_q[ROM_LAT] ? (NUM_REQ'(1) << tag_pipe_q[ROM_LAT]) : '0;
    assign rsp_cost  = vld_pipe_q[ROM_LAT] ? rom_Cost : '0;
    assign busy      = (state_q == LOCK) | (|vld_pipe_q) | (|gnt);

endmodule

// File: tb/tb_jam_cost_rom_arbiter.sv
// Bench: two arbiters (ROM_LAT=1 and ROM_LAT=0) share one stimulus stream and are
// compared each cycle against a cycle-level model of the grant/response rules.
module tb_jam_cost_rom_arbiter;

    localparam int N = 4;
`ifdef JAM_ARB_LOCK_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [N-1:0]  req = '0, lock = '0;
    logic [3*N-1:0] req_w = '0, req_j = '0;
    logic [N-1:0]  gnt0, gnt1, rv0, rv1;
    logic [6:0]    rc0, rc1, rom_cost0, rom_cost1;
    logic [2:0]    rw0, rj0, rw1, rj1;
    logic          busy0, busy1;
    logic [6:0]    tbl [0:63];

    always #5 CLK = ~CLK;

    always @(posedge CLK) rom_cost0 <= tbl[{rw0, rj0}];
    assign rom_cost1 = tbl[{rw1, rj1}];

    jam_cost_rom_arbiter #(.NUM_REQ(N), .ROM_LAT(1)) dut0 (
        .CLK(CLK), .RST(RST), .req(req), .lock(lock), .req_w(req_w), .req_j(req_j),
        .gnt(gnt0), .rsp_valid(rv0), .rsp_cost(rc0), .rom_W(rw0), .rom_J(rj0),
        .rom_Cost(rom_cost0), .busy(busy0));

    jam_cost_rom_arbiter #(.NUM_REQ(N), .ROM_LAT(0)) dut1 (
        .CLK(CLK), .RST(RST), .req(req), .lock(lock), .req_w(req_w), .req_j(req_j),
        .gnt(gnt1), .rsp_valid(rv1), .rsp_cost(rc1), .rom_W(rw1), .rom_J(rj1),
        .rom_Cost(rom_cost1), .busy(busy1));

    int         n_checks = 0, n_fail = 0;
    int         cyc = 0, m_ptr = 0, m_owner = -1, m_burst = 0, last_acc = -100;
    logic [2:0] m_w = '0, m_j = '0;
    logic [3:0] ev0 [0:4095];
    logic [3:0] ev1 [0:4095];
    logic [6:0] ec0 [0:4095];
    logic [6:0] ec1 [0:4095];
    logic [3:0] last_gnt;

    task automatic clear_model();
        m_ptr = 0; m_owner = -1; m_burst = 0; last_acc = -100; m_w = '0; m_j = '0;
        for (int i = 0; i < 4096; i++) begin
            ev0[i] = '0; ev1[i] = '0; ec0[i] = '0; ec1[i] = '0;
        end
    endtask

    // One clock cycle: drive, predict, check at mid-cycle, then advance the model.
    task automatic step(input logic [3:0] r, input logic [3:0] l,
                        input logic [11:0] wv, input logic [11:0] jv);
        int win;
        int a;
        logic [3:0] eg;
        logic eb0, eb1;
        @(posedge CLK); #1;
        req = r; lock = l; req_w = wv; req_j = jv;
        win = -1;
        if (m_owner >= 0 && r[m_owner] && l[m_owner]) win = m_owner;
        else for (int k = 0; k < N; k++) if (win < 0 && r[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        eg  = (win >= 0) ? 4'(1 << win) : 4'b0;
        eb0 = (m_owner >= 0) || (cyc - last_acc <= 2) || (win >= 0);
        eb1 = (m_owner >= 0) || (cyc - last_acc <= 1) || (win >= 0);
        #3;
        n_checks++;
        if (gnt0 !== eg || gnt1 !== eg) begin
            n_fail++;
            $display("FAIL grant cyc=%0d got=%b/%b exp=%b", cyc, gnt0, gnt1, eg);
        end
        n_checks++;
        if ({rv0, rc0, rw0, rj0, busy0} !== {ev0[cyc], ec0[cyc], m_w, m_j, eb0}) begin
            n_fail++;
            $display("FAIL lat1 cyc=%0d got v=%b c=%0d w=%0d j=%0d busy=%b exp v=%b c=%0d w=%0d j=%0d busy=%b",
                     cyc, rv0, rc0, rw0, rj0, busy0, ev0[cyc], ec0[cyc], m_w, m_j, eb0);
        end
        n_checks++;
        if ({rv1, rc1, rw1, rj1, busy1} !== {ev1[cyc], ec1[cyc], m_w, m_j, eb1}) begin
            n_fail++;
            $display("FAIL lat0 cyc=%0d got v=%b c=%0d w=%0d j=%0d busy=%b exp v=%b c=%0d w=%0d j=%0d busy=%b",
                     cyc, rv1, rc1, rw1, rj1, busy1, ev1[cyc], ec1[cyc], m_w, m_j, eb1);
        end
        last_gnt = gnt0;
        if (win >= 0) begin
            m_w = wv[win*3 +: 3];
            m_j = jv[win*3 +: 3];
            a = int'({m_w, m_j});
            ev0[cyc+2] = eg; ec0[cyc+2] = tbl[a];
            ev1[cyc+1] = eg; ec1[cyc+1] = tbl[a];
            last_acc = cyc;
            m_ptr = (win + 1) % N;
            if (l[win]) begin
                if (win == m_owner) m_burst++;
                else begin m_owner = win; m_burst = 1; end
                if (LIMIT && m_burst == 8) begin m_owner = -1; m_burst = 0; end
            end else m_owner = -1;
        end else m_owner = -1;
        cyc++;
    endtask

    task automatic do_reset();
        @(posedge CLK); #1;
        RST = 1'b1; req = '0; lock = '0;
        #3;
        n_checks++;
        if ({gnt0, rv0, rc0, rw0, rj0, busy0, gnt1, rv1, rc1, rw1, rj1, busy1} !== '0) begin
            n_fail++;
            $display("FAIL reset_state got g=%b v=%b c=%0d w=%0d j=%0d b=%b / g=%b v=%b c=%0d w=%0d j=%0d b=%b exp all 0",
                     gnt0, rv0, rc0, rw0, rj0, busy0, gnt1, rv1, rc1, rw1, rj1, busy1);
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        clear_model();
        cyc += 4;
    endtask

    task automatic test_reset();
        do_reset();
        step(4'b0000, 4'b0000, 12'h0, 12'h0);
    endtask

    task automatic test_single();
        do_reset();
        step(4'b0100, 4'b0000, 12'(5) << 6, 12'(3) << 6);
        n_checks++;
        if (last_gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=0100", last_gnt); end
        step(4'b0000, 4'b0000, 12'h0, 12'h0);
        n_checks++;
        if (rw0 !== 3'd5 || rj0 !== 3'd3) begin n_fail++; $display("FAIL single_addr got=%0d,%0d exp=5,3", rw0, rj0); end
        step(4'b0000, 4'b0000, 12'h0, 12'h0);
        n_checks++;
        if (rv0 !== 4'b0100 || rc0 !== 7'd42) begin n_fail++; $display("FAIL single_rsp got=%b/%0d exp=0100/42", rv0, rc0); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 0; k < 8; k++) begin
            step(4'b1111, 4'b0000, 12'($urandom), 12'($urandom));
            n_checks++;
            if (last_gnt !== 4'(1 << (k % 4))) begin
                n_fail++; $display("FAIL fair_order k=%0d got=%b exp=%b", k, last_gnt, 4'(1 << (k % 4)));
            end
        end
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 12'h0, 12'h0);
    endtask

    task automatic test_lock();
        int held;
        logic [3:0] order [0:2];
        do_reset();
        step(4'b1111, 4'b0010, 12'($urandom), 12'($urandom));
        held = 0;
        for (int k = 0; k < 5; k++) begin
            step(4'b1111, 4'b0010, 12'($urandom), 12'($urandom));
            if (last_gnt === 4'b0010) held++;
        end
        n_checks++;
        if (held !== 5) begin n_fail++; $display("FAIL lock_hold got=%0d exp=5", held); end
        order[0] = 4'b0100; order[1] = 4'b1000; order[2] = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step(4'b1111, 4'b0000, 12'($urandom), 12'($urandom));
            n_checks++;
            if (last_gnt !== order[k]) begin n_fail++; $display("FAIL lock_release k=%0d got=%b exp=%b", k, last_gnt, order[k]); end
        end
        step(4'b1111, 4'b0000, 12'($urandom), 12'($urandom));
        n_checks++;
        if (last_gnt !== 4'b0010) begin n_fail++; $display("FAIL lock_owner_last got=%b exp=0010", last_gnt); end
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 12'h0, 12'h0);
    endtask

    task automatic test_lock_limit();
        int run;
        bit broken;
        do_reset();
        run = 0; broken = 0;
        for (int k = 0; k < 12; k++) begin
            step(4'b0011, 4'b0001, 12'($urandom), 12'($urandom));
            if (!broken && last_gnt === 4'b0001) run++;
            else broken = 1;
        end
        n_checks++;
        if (run !== (LIMIT ? 8 : 12)) begin n_fail++; $display("FAIL lock_limit_run got=%0d exp=%0d", run, LIMIT ? 8 : 12); end
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 12'h0, 12'h0);
    endtask

    task automatic test_reset_flush();
        do_reset();
        step(4'b0010, 4'b0000, 12'($urandom), 12'($urandom));
        do_reset();
        for (int k = 0; k < 3; k++) begin
            step(4'b0000, 4'b0000, 12'h0, 12'h0);
            n_checks++;
            if (rv0 !== 4'b0 || rv1 !== 4'b0) begin n_fail++; $display("FAIL flush_rsp k=%0d got=%b/%b exp=0000", k, rv0, rv1); end
        end
        step(4'b1111, 4'b0000, 12'($urandom), 12'($urandom));
        n_checks++;
        if (last_gnt !== 4'b0001) begin n_fail++; $display("FAIL flush_ptr got=%b exp=0001", last_gnt); end
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 12'h0, 12'h0);
    endtask

    task automatic test_zero_latency();
        logic [3:0] prev;
        do_reset();
        prev = '0;
        for (int k = 0; k < 8; k++) begin
            step((k % 2) ? 4'b1000 : 4'b0001, 4'b0000, 12'($urandom), 12'($urandom));
            n_checks++;
            if (rv1 !== prev) begin n_fail++; $display("FAIL zero_lat k=%0d got=%b exp=%b", k, rv1, prev); end
            prev = last_gnt;
        end
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 12'h0, 12'h0);
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 300; k++)
            step(4'($urandom), 4'($urandom & $urandom), 12'($urandom), 12'($urandom));
        for (int k = 0; k < 3; k++) step(4'b0000, 4'b0000, 12'h0, 12'h0);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) tbl[i] = 7'($urandom);
        tbl[43] = 7'd42;
        clear_model();
        test_reset();
        test_single();
        test_back_to_back();
        test_lock();
        test_lock_limit();
        test_reset_flush();
        test_zero_latency();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
